// File: rtl/pes_elevator_pkg.sv
// Shared types for the pes_elc elevator scheduler: FSM state encoding and travel direction.
package pes_elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DOOR   = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pes_elevator_dir_sel.sv
// SCAN direction selector: flags requests above/below the cabin and picks the next direction.
// Purely combinational; keeps heading while work lies ahead, reverses otherwise, holds when idle.
module pes_elevator_dir_sel
  import pes_elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]    i_floor,
  input  logic                  i_dir,
  output logic                  o_any_above,
  output logic                  o_any_below,
  output logic                  o_next_dir
);

  always_comb begin
    o_any_above = 1'b0;
    o_any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_pending[i] && (i > int'(i_floor))) o_any_above = 1'b1;
      if (i_pending[i] && (i < int'(i_floor))) o_any_below = 1'b1;
    end
  end

  // With nothing pending on either side the current direction is retained.
  always_comb begin
    if (i_dir == DIR_UP) begin
      o_next_dir = (o_any_above || !o_any_below) ? DIR_UP : DIR_DOWN;
    end else begin
      o_next_dir = (o_any_below || !o_any_above) ? DIR_DOWN : DIR_UP;
    end
  end

endmodule

// File: rtl/pes_elevator_sched.sv
// SCAN elevator controller: latched request bitmap, timed travel and door dwell, door interlocks.
// Request visible in pending one cycle later, motion starts the cycle after; interlocks stall the door timer.
module pes_elevator_sched
  import pes_elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6,
  parameter int ALERT_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    in_current_floor,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  over_time,
  input  logic                  over_weight,
  output logic [FLOOR_W-1:0]    out_current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  complete,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  req_error,
  output logic                  door_alert,
  output logic                  weight_alert
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam int OW = $clog2(ALERT_CYCLES + 1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  state_e                  r_state;
  logic [FLOOR_W-1:0]      r_floor;
  logic                    r_dir;
  logic [NUM_FLOORS-1:0]   r_pending;
  logic [TW-1:0]           r_travel_cnt;
  logic [DW-1:0]           r_door_cnt;
  logic [OW-1:0]           r_obst_cnt;
  logic                    r_complete;
  logic                    r_req_error;
  logic                    r_door_alert;
  logic                    r_weight_alert;

  logic                    w_req_ok;
  logic                    w_req_same;
  logic [NUM_FLOORS-1:0]   w_req_onehot;
  logic [FLOOR_W-1:0]      w_step_floor;
  logic [NUM_FLOORS-1:0]   w_step_onehot;
  logic                    w_arrive;
  logic                    w_hit;
  logic                    w_door_restart;
  logic [NUM_FLOORS-1:0]   w_set_mask;
  logic [NUM_FLOORS-1:0]   w_clr_mask;
  logic                    w_any_above;
  logic                    w_any_below;
  logic                    w_next_dir;

  pes_elevator_dir_sel #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_dir_sel (
    .i_pending   (r_pending),
    .i_floor     (r_floor),
    .i_dir       (r_dir),
    .o_any_above (w_any_above),
    .o_any_below (w_any_below),
    .o_next_dir  (w_next_dir)
  );

  assign w_req_ok      = req_valid && (int'(req_floor) < NUM_FLOORS);
  assign w_req_same    = (req_floor == r_floor);
  assign w_req_onehot  = ONE_HOT0 << req_floor;
  assign w_step_floor  = (r_dir == DIR_UP) ? r_floor + 1'b1 : r_floor - 1'b1;
  assign w_step_onehot = ONE_HOT0 << w_step_floor;
  assign w_arrive      = (r_state == ST_MOVING) && (r_travel_cnt == TW'(TRAVEL_CYCLES - 1));
  assign w_hit         = |(r_pending & w_step_onehot);
  assign w_door_restart = (r_state == ST_DOOR) && w_req_ok && w_req_same;

  // A request for the floor the cabin is standing at (idle or doors open) is served in place.
  assign w_set_mask = (w_req_ok && !(w_req_same && (r_state != ST_MOVING))) ? w_req_onehot : '0;
  // Clearing is applied after setting so an arrival wins over a same-cycle request.
  assign w_clr_mask = (w_arrive && w_hit) ? w_step_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_floor        <= in_current_floor;
      r_dir          <= DIR_UP;
      r_pending      <= '0;
      r_travel_cnt   <= '0;
      r_door_cnt     <= '0;
      r_obst_cnt     <= '0;
      r_complete     <= 1'b0;
      r_req_error    <= 1'b0;
      r_door_alert   <= 1'b0;
      r_weight_alert <= 1'b0;
    end else begin
      r_pending      <= (r_pending | w_set_mask) & ~w_clr_mask;
      r_complete     <= 1'b0;
      r_req_error    <= req_valid && !w_req_ok;
      r_obst_cnt     <= '0;
      r_door_alert   <= 1'b0;
      r_weight_alert <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_req_ok && w_req_same) begin
            r_state    <= ST_DOOR;
            r_complete <= 1'b1;
            r_door_cnt <= '0;
          end else if (w_any_above || w_any_below) begin
            r_state      <= ST_MOVING;
            r_dir        <= w_next_dir;
            r_travel_cnt <= '0;
          end
        end

        ST_MOVING: begin
          if (w_arrive) begin
            r_floor      <= w_step_floor;
            r_travel_cnt <= '0;
            if (w_hit) begin
              r_state    <= ST_DOOR;
              r_complete <= 1'b1;
              r_door_cnt <= '0;
            end
          end else begin
            r_travel_cnt <= r_travel_cnt + 1'b1;
          end
        end

        ST_DOOR: begin
          if (w_door_restart) begin
            r_door_cnt <= '0;
          end else if (!over_time && !over_weight) begin
            if (r_door_cnt == DW'(DOOR_CYCLES - 1)) begin
              r_state    <= ST_IDLE;
              r_door_cnt <= '0;
            end else begin
              r_door_cnt <= r_door_cnt + 1'b1;
            end
          end
          // Obstruction count saturates; the alert fires on the edge the count reaches its limit.
          if (over_time) begin
            r_obst_cnt   <= (r_obst_cnt == OW'(ALERT_CYCLES)) ? r_obst_cnt : r_obst_cnt + 1'b1;
            r_door_alert <= (r_obst_cnt >= OW'(ALERT_CYCLES - 1));
          end
          r_weight_alert <= over_weight;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_current_floor = r_floor;
  assign direction         = r_dir;
  assign moving            = (r_state == ST_MOVING);
  assign door_open         = (r_state == ST_DOOR);
  assign complete          = r_complete;
  assign pending           = r_pending;
  assign req_error         = r_req_error;
  assign door_alert        = r_door_alert;
  assign weight_alert      = r_weight_alert;

endmodule

// File: tb/tb_pes_elevator_sched.sv
// Bench for pes_elevator_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_pes_elevator_sched;

  localparam int NF = 8;
  localparam int FW = 4;
  localparam int TC = 4;
  localparam int DC = 6;
  localparam int AC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] in_current_floor;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          over_time;
  logic          over_weight;
  logic [FW-1:0] out_current_floor;
  logic          direction;
  logic          moving;
  logic          door_open;
  logic          complete;
  logic [NF-1:0] pending;
  logic          req_error;
  logic          door_alert;
  logic          weight_alert;

  always #5 clk = ~clk;

  pes_elevator_sched #(
    .NUM_FLOORS    (NF),
    .FLOOR_W       (FW),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC),
    .ALERT_CYCLES  (AC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_current_floor  (in_current_floor),
    .req_valid         (req_valid),
    .req_floor         (req_floor),
    .over_time         (over_time),
    .over_weight       (over_weight),
    .out_current_floor (out_current_floor),
    .direction         (direction),
    .moving            (moving),
    .door_open         (door_open),
    .complete          (complete),
    .pending           (pending),
    .req_error         (req_error),
    .door_alert        (door_alert),
    .weight_alert      (weight_alert)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 0 = idle, 1 = travelling, 2 = doors open; timers count cycles remaining.
  int m_st, m_floor, m_dir, m_tleft, m_dleft, m_obst;
  bit m_pend [NF];
  bit m_comp, m_rerr, m_dalert, m_walert;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NF-1:0] m_pend_vec();
    logic [NF-1:0] v;
    for (int f = 0; f < NF; f++) v[f] = m_pend[f];
    return v;
  endfunction

  task automatic model_step();
    bit ok, above, below;
    int rf, setf, clrf, old_obst;
    if (reset) begin
      m_st = 0; m_floor = int'(in_current_floor); m_dir = 1;
      for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
      m_tleft = 0; m_dleft = 0; m_obst = 0;
      m_comp = 0; m_rerr = 0; m_dalert = 0; m_walert = 0;
    end else begin
      rf       = int'(req_floor);
      ok       = req_valid && (rf < NF);
      setf     = ok ? rf : -1;
      clrf     = -1;
      old_obst = m_obst;
      m_rerr   = req_valid && !ok;
      m_comp   = 0;
      m_obst   = 0; m_dalert = 0; m_walert = 0;
      case (m_st)
        0: begin
          if (ok && rf == m_floor) begin
            m_st = 2; m_comp = 1; m_dleft = DC; setf = -1;
          end else begin
            above = 0; below = 0;
            for (int f = 0; f < NF; f++) begin
              if (m_pend[f] && f > m_floor) above = 1;
              if (m_pend[f] && f < m_floor) below = 1;
            end
            if (above || below) begin
              if (m_dir == 1) m_dir = above ? 1 : 0;
              else            m_dir = below ? 0 : 1;
              m_st = 1; m_tleft = TC;
            end
          end
        end
        1: begin
          if (m_tleft == 1) begin
            m_floor = m_floor + ((m_dir == 1) ? 1 : -1);
            m_tleft = TC;
            if (m_pend[m_floor]) begin
              clrf = m_floor; m_comp = 1; m_st = 2; m_dleft = DC;
            end
          end else begin
            m_tleft--;
          end
        end
        default: begin
          if (ok && rf == m_floor) begin
            m_dleft = DC; setf = -1;
          end else if (!over_time && !over_weight) begin
            if (m_dleft == 1) m_st = 0;
            else m_dleft--;
          end
          if (over_time) begin
            m_obst   = (old_obst + 1 > AC) ? AC : old_obst + 1;
            m_dalert = (m_obst >= AC);
          end
          m_walert = over_weight;
        end
      endcase
      if (setf >= 0 && setf != clrf) m_pend[setf] = 1'b1;
      if (clrf >= 0) m_pend[clrf] = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("floor",        32'(out_current_floor), 32'(m_floor));
    chk("direction",    32'(direction),         32'(m_dir));
    chk("moving",       32'(moving),            32'(m_st == 1));
    chk("door_open",    32'(door_open),         32'(m_st == 2));
    chk("complete",     32'(complete),          32'(m_comp));
    chk("pending",      32'(pending),           32'(m_pend_vec()));
    chk("req_error",    32'(req_error),         32'(m_rerr));
    chk("door_alert",   32'(door_alert),        32'(m_dalert));
    chk("weight_alert", 32'(weight_alert),      32'(m_walert));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset(input int floor);
    reset = 1'b1; in_current_floor = FW'(floor);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    int first_move, first_comp, door_n, close_k, dir_at2, k, first_alert;
    int done_floors [$];
    int ot_left, ow_left;

    reset = 1'b1; in_current_floor = '0; req_valid = 1'b0; req_floor = '0;
    over_time = 1'b0; over_weight = 1'b0;

    // Reset state and a full descent from floor 7 to floor 0.
    do_reset(7);
    chk("rst_floor", 32'(out_current_floor), 32'd7);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_dir", 32'(direction), 32'd1);
    req_valid = 1'b1; req_floor = 4'd0;
    cyc();
    req_valid = 1'b0;
    chk("req_pending_n1", 32'(pending), 32'h01);
    first_move = -1; first_comp = -1; door_n = 0; close_k = -1; dir_at2 = -1; k = 1;
    repeat (45) begin
      if (moving && first_move < 0) first_move = k;
      if (k == 2) dir_at2 = int'(direction);
      if (complete && first_comp < 0) first_comp = k;
      if (door_open) door_n++;
      if (first_comp > 0 && !door_open && !moving && close_k < 0) close_k = k;
      cyc();
      k++;
    end
    chk("d1_move_start", 32'(first_move), 32'd2);
    chk("d1_dir_down", 32'(dir_at2), 32'd0);
    chk("d1_complete_at", 32'(first_comp), 32'd30);
    chk("d1_door_cycles", 32'(door_n), 32'd6);
    chk("d1_idle_at", 32'(close_k), 32'd36);
    chk("d1_floor", 32'(out_current_floor), 32'd0);

    // Going up 3 -> 6 with a request for 1 appearing mid-move.
    do_reset(3);
    req_valid = 1'b1; req_floor = 4'd6;
    cyc();
    req_valid = 1'b0;
    cyc(); cyc(); cyc();
    req_valid = 1'b1; req_floor = 4'd1;
    cyc();
    req_valid = 1'b0;
    repeat (150) begin
      if (complete) done_floors.push_back(int'(out_current_floor));
      cyc();
    end
    chk("d2_stops", 32'(done_floors.size()), 32'd2);
    if (done_floors.size() == 2) begin
      chk("d2_first", 32'(done_floors[0]), 32'd6);
      chk("d2_second", 32'(done_floors[1]), 32'd1);
    end
    chk("d2_pending", 32'(pending), 32'd0);

    // Request for the current floor while idle, then an overload hold.
    do_reset(2);
    req_valid = 1'b1; req_floor = 4'd2;
    cyc();
    req_valid = 1'b0;
    chk("d3_complete", 32'(complete), 32'd1);
    chk("d3_door", 32'(door_open), 32'd1);
    chk("d3_pending", 32'(pending), 32'd0);
    over_weight = 1'b1;
    repeat (20) cyc();
    chk("d4_walert", 32'(weight_alert), 32'd1);
    chk("d4_door_held", 32'(door_open), 32'd1);
    over_weight = 1'b0;
    door_n = 0;
    repeat (10) begin
      if (door_open) door_n++;
      cyc();
    end
    chk("d4_close_after", 32'(door_n), 32'd6);

    // Obstruction alert timing.
    req_valid = 1'b1; req_floor = 4'd2;
    cyc();
    req_valid = 1'b0;
    over_time = 1'b1;
    first_alert = -1; k = 0;
    repeat (10) begin
      cyc();
      k++;
      if (door_alert && first_alert < 0) first_alert = k;
    end
    chk("d5_alert_at", 32'(first_alert), 32'd8);
    over_time = 1'b0;
    cyc();
    chk("d5_alert_clr", 32'(door_alert), 32'd0);
    repeat (8) cyc();

    // Out-of-range request, then reset while travelling.
    req_valid = 1'b1; req_floor = 4'd9;
    cyc();
    req_valid = 1'b0;
    chk("d6_req_error", 32'(req_error), 32'd1);
    chk("d6_pending", 32'(pending), 32'd0);
    req_valid = 1'b1; req_floor = 4'd7;
    cyc();
    req_valid = 1'b0;
    repeat (6) cyc();
    chk("d6_moving", 32'(moving), 32'd1);
    in_current_floor = 4'd4; reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("d6_rst_pending", 32'(pending), 32'd0);
    chk("d6_rst_idle", 32'(moving | door_open), 32'd0);
    chk("d6_rst_floor", 32'(out_current_floor), 32'd4);

    // Randomized traffic with interlock bursts and occasional resets.
    ot_left = 0; ow_left = 0;
    repeat (4000) begin
      reset            = ($urandom_range(0, 499) == 0);
      in_current_floor = FW'($urandom_range(0, NF - 1));
      req_valid        = ($urandom_range(0, 5) == 0);
      req_floor        = FW'($urandom_range(0, 9));
      if (ot_left > 0) ot_left--;
      else if ($urandom_range(0, 59) == 0) ot_left = $urandom_range(1, 12);
      if (ow_left > 0) ow_left--;
      else if ($urandom_range(0, 79) == 0) ow_left = $urandom_range(1, 8);
      over_time   = (ot_left > 0);
      over_weight = (ow_left > 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
